// File: rtl/reset_request_gen.sv
// Initiator side of the board reset path: issues timed reset requests from software or a
// watchdog, then confirms assert and release through the reset block's feedback.
module reset_request_gen #(
    parameter int unsigned REQ_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned WDOG_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  ip_async_reset_i,
    input  logic                  sw_req_i,
    input  logic                  wdog_kick_i,
    input  logic [WDOG_WIDTH-1:0] wdog_limit_i,
    input  logic                  rst_fb_i,
    input  logic                  err_clr_i,
    output logic                  op_reset_req_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_timeout_o,
    output logic                  wdog_fired_o,
    output logic [7:0]            req_count_o
);

    localparam int unsigned CntMax = (REQ_WIDTH > TIMEOUT) ? REQ_WIDTH : TIMEOUT;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0]       ReqLast = CntW'(REQ_WIDTH - 1);
    localparam logic [CntW-1:0]       ToLast  = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0]       CntOne  = CntW'(1);
    localparam logic [WDOG_WIDTH-1:0] WdOne   = WDOG_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StWaitAck,
        StWaitRel,
        StDone
    } state_t;

    state_t                state, state_next;
    logic [CntW-1:0]       cnt, cnt_next;
    logic [WDOG_WIDTH-1:0] wd_cnt, wd_cnt_next;
    logic                  req, req_next;
    logic                  done, done_next;
    logic                  err, err_next;
    logic                  wdog_fired, wdog_fired_next;
    logic [7:0]            count, count_next;
    logic                  fb_meta, fb_s;
    logic [1:0]            rst_pipe;
    logic                  rst;
    logic                  idle, wd_on, expire;

    // Asynchronous assertion, release aligned to clk.
    always_ff @(posedge clk or posedge ip_async_reset_i) begin
        if (ip_async_reset_i) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end
    assign rst = rst_pipe[1];

    assign idle   = (state == StIdle);
    assign wd_on  = (wdog_limit_i != '0);
    assign expire = idle && wd_on && !wdog_kick_i && (wd_cnt == wdog_limit_i - WdOne);

    always_comb begin
        wd_cnt_next = wd_cnt;
        if (wdog_kick_i || !idle || expire) begin
            wd_cnt_next = '0;
        end else if (wd_on) begin
            wd_cnt_next = wd_cnt + WdOne;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        req_next        = 1'b0;
        done_next       = 1'b0;
        err_next        = err;
        wdog_fired_next = wdog_fired;
        count_next      = count;

        // Clear first so a same-cycle set event below takes priority.
        if (err_clr_i) begin
            err_next        = 1'b0;
            wdog_fired_next = 1'b0;
        end

        unique case (state)
            StIdle: begin
                if (sw_req_i || expire) begin
                    state_next = StAssert;
                    cnt_next   = '0;
                    req_next   = 1'b1;
                    if (expire) begin
                        wdog_fired_next = 1'b1;
                    end
                end
            end
            StAssert: begin
                if (cnt == ReqLast) begin
                    state_next = StWaitAck;
                    cnt_next   = '0;
                end else begin
                    req_next = 1'b1;
                    cnt_next = cnt + CntOne;
                end
            end
            StWaitAck: begin
                if (fb_s) begin
                    state_next = StWaitRel;
                    cnt_next   = '0;
                end else if (cnt == ToLast) begin
                    err_next   = 1'b1;
                    state_next = StIdle;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CntOne;
                end
            end
            StWaitRel: begin
                if (!fb_s) begin
                    state_next = StDone;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    count_next = count + 8'd1;
                end else if (cnt == ToLast) begin
                    err_next   = 1'b1;
                    state_next = StIdle;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CntOne;
                end
            end
            StDone: begin
                state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            wd_cnt     <= '0;
            req        <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wdog_fired <= 1'b0;
            count      <= 8'd0;
            fb_meta    <= 1'b0;
            fb_s       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            wd_cnt     <= wd_cnt_next;
            req        <= req_next;
            done       <= done_next;
            err        <= err_next;
            wdog_fired <= wdog_fired_next;
            count      <= count_next;
            fb_meta    <= rst_fb_i;
            fb_s       <= fb_meta;
        end
    end

    assign op_reset_req_o = req;
    assign busy_o         = !idle;
    assign done_o         = done;
    assign err_timeout_o  = err;
    assign wdog_fired_o   = wdog_fired;
    assign req_count_o    = count;

endmodule
